// File: rtl/hand_tx_arb.sv
// rtl/hand_tx_arb.sv - round-robin byte arbiter driving a 4-phase req/ack link
// Optional handshake phase timeout is built when HAND_ARB_TIMEOUT_EN is defined.
module hand_tx_arb #(
  parameter int NUM_SRC = 4,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic                        tx_clk,
  input  logic                        reset,
  input  logic [NUM_SRC-1:0]          src_valid,
  input  logic [NUM_SRC*DATA_W-1:0]   src_data,
  output logic [NUM_SRC-1:0]          src_ready,
  input  logic                        ack,
  output logic                        req,
  output logic [DATA_W-1:0]           tx_data_out,
  output logic [$clog2(NUM_SRC)-1:0]  grant_id,
  output logic                        busy,
  output logic                        err
);

  localparam int ID_W = $clog2(NUM_SRC);

  typedef enum logic [1:0] {IDLE, SETUP, WAIT_ACK, WAIT_REL} state_t;

  state_t              state, state_nxt;
  logic                ack_meta, ack_s;
  logic [NUM_SRC-1:0]  rr_ptr, rr_ptr_nxt;
  logic                req_nxt;
  logic [DATA_W-1:0]   data_nxt;
  logic [ID_W-1:0]     grant_nxt;
  logic                win_found;
  logic [ID_W-1:0]     win_idx;
  logic [DATA_W-1:0]   win_data;
  logic                grant;

  always_ff @(posedge tx_clk or posedge reset) begin
    if (reset) begin
      ack_meta <= 1'b0;
      ack_s    <= 1'b0;
    end else begin
      ack_meta <= ack;
      ack_s    <= ack_meta;
    end
  end

  // Smallest offset k from rr_ptr wins: later (smaller) k overwrites earlier ones.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (src_valid[i] && ((32'(rr_ptr) + 32'(k)) % 32'(NUM_SRC)) == 32'(i)) begin
          win_found = 1'b1;
          win_idx   = ID_W'(i);
        end
      end
    end
  end

  always_comb begin
    win_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (win_idx == ID_W'(i)) win_data = src_data[i*DATA_W +: DATA_W];
    end
  end

  // A stale ack still visible after the last release blocks new grants.
  assign grant = !reset && (state == IDLE) && !ack_s && win_found;

  always_comb begin
    src_ready = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      src_ready[i] = grant && (win_idx == ID_W'(i));
    end
  end

  assign busy = (state != IDLE);

`ifdef HAND_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] phase_cnt;
  logic             err_nxt;
  logic             phase_expired;

  assign phase_expired = (phase_cnt == CNT_LAST);

  always_ff @(posedge tx_clk or posedge reset) begin
    if (reset) begin
      phase_cnt <= '0;
      err       <= 1'b0;
    end else begin
      err <= err_nxt;
      if (state_nxt != state)
        phase_cnt <= '0;
      else if (state == WAIT_ACK || state == WAIT_REL)
        phase_cnt <= phase_cnt + 1'b1;
    end
  end
`else
  // Constant 0; TIMEOUT only matters when the phase counter is built.
  assign err = (TIMEOUT < 0);
`endif

  always_comb begin
    state_nxt  = state;
    req_nxt    = req;
    data_nxt   = tx_data_out;
    grant_nxt  = grant_id;
    rr_ptr_nxt = rr_ptr;
`ifdef HAND_ARB_TIMEOUT_EN
    err_nxt    = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (grant) begin
          state_nxt  = SETUP;
          data_nxt   = win_data;
          grant_nxt  = win_idx;
          rr_ptr_nxt = (win_idx == ID_W'(NUM_SRC - 1)) ? '0
                                                       : NUM_SRC'(win_idx) + NUM_SRC'(1);
        end
      end
      SETUP: begin
        state_nxt = WAIT_ACK;
        req_nxt   = 1'b1;
      end
      WAIT_ACK: begin
        if (ack_s) begin
          req_nxt   = 1'b0;
          state_nxt = WAIT_REL;
        end
`ifdef HAND_ARB_TIMEOUT_EN
        else if (phase_expired) begin
          req_nxt   = 1'b0;
          err_nxt   = 1'b1;
          state_nxt = WAIT_REL;
        end
`endif
      end
      WAIT_REL: begin
        if (!ack_s) begin
          state_nxt = IDLE;
        end
`ifdef HAND_ARB_TIMEOUT_EN
        else if (phase_expired) begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge tx_clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      req         <= 1'b0;
      tx_data_out <= '0;
      grant_id    <= '0;
      rr_ptr      <= '0;
    end else begin
      state       <= state_nxt;
      req         <= req_nxt;
      tx_data_out <= data_nxt;
      grant_id    <= grant_nxt;
      rr_ptr      <= rr_ptr_nxt;
    end
  end

endmodule

// File: tb/tb_hand_tx_arb.sv
// tb/tb_hand_tx_arb.sv - self-checking bench for hand_tx_arb with a queue-based round-robin model
module tb_hand_tx_arb;

  localparam int NS = 4;
  localparam int DW = 8;
  localparam int TO = 16;

  logic            tx_clk = 1'b0;
  logic            reset;
  logic [NS-1:0]   src_valid;
  logic [NS*DW-1:0] src_data;
  logic [NS-1:0]   src_ready;
  logic            ack;
  logic            req;
  logic [DW-1:0]   tx_data_out;
  logic [1:0]      grant_id;
  logic            busy;
  logic            err;

  int vectors = 0;
  int miscompares = 0;

  logic [DW-1:0] src_q [NS][$];
  int            exp_id [$];
  logic [DW-1:0] exp_byte [$];
  int            mdl_ptr;

  hand_tx_arb #(.NUM_SRC(NS), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .tx_clk     (tx_clk),
    .reset      (reset),
    .src_valid  (src_valid),
    .src_data   (src_data),
    .src_ready  (src_ready),
    .ack        (ack),
    .req        (req),
    .tx_data_out(tx_data_out),
    .grant_id   (grant_id),
    .busy       (busy),
    .err        (err)
  );

  always #5 tx_clk = ~tx_clk;

  task automatic do_reset();
    reset = 1'b1;
    ack = 1'b0;
    src_valid = '0;
    src_data = '0;
    repeat (2) @(negedge tx_clk);
    reset = 1'b0;
  endtask

  // Expected transfer order from plain round-robin over the loaded queues.
  task automatic build_expected();
    int pos [NS];
    int remaining;
    remaining = 0;
    exp_id.delete();
    exp_byte.delete();
    for (int i = 0; i < NS; i++) begin
      pos[i] = 0;
      remaining += src_q[i].size();
    end
    while (remaining > 0) begin
      for (int k = 0; k < NS; k++) begin
        int idx;
        idx = (mdl_ptr + k) % NS;
        if (src_q[idx].size() > pos[idx]) begin
          exp_id.push_back(idx);
          exp_byte.push_back(src_q[idx][pos[idx]]);
          pos[idx]++;
          mdl_ptr = (idx + 1) % NS;
          remaining--;
          break;
        end
      end
    end
  endtask

  // Drives sources from src_q, echoes req onto ack dly cycles later, checks against exp_*.
  task automatic run_traffic(input int dly, input int max_cycles);
    logic [7:0] hist;
    logic       prev_req;
    int         rises, grants, n, cyc, pop_src;
    hist = '0;
    prev_req = req;
    rises = 0;
    grants = 0;
    n = exp_id.size();
    cyc = 0;
    pop_src = -1;
    while (!(rises == n && grants == n && !busy && !req) && cyc < max_cycles) begin
      @(negedge tx_clk);
      cyc++;
      if (pop_src >= 0) begin
        void'(src_q[pop_src].pop_front());
        pop_src = -1;
      end
      hist = {hist[6:0], req};
      ack = hist[dly-1];
      for (int i = 0; i < NS; i++) begin
        src_valid[i] = (src_q[i].size() > 0);
        src_data[i*DW +: DW] = (src_q[i].size() > 0) ? src_q[i][0] : 8'h00;
      end
      #1;
      if (src_ready != '0) begin
        vectors++;
        if (grants >= n || src_ready !== (NS'(1) << exp_id[grants])) begin
          miscompares++;
          $display("FAIL grant_order: got src_ready=%b want source %0d (grant #%0d)",
                   src_ready, (grants < n) ? exp_id[grants] : -1, grants);
        end
        for (int i = 0; i < NS; i++) if (src_ready[i]) pop_src = i;
        grants++;
      end
      if (req && !prev_req) begin
        vectors++;
        if (rises >= n || tx_data_out !== exp_byte[rises] || grant_id !== 2'(exp_id[rises])) begin
          miscompares++;
          $display("FAIL link_byte: got data=%h id=%0d want data=%h id=%0d (xfer #%0d)",
                   tx_data_out, grant_id, (rises < n) ? exp_byte[rises] : 8'h00,
                   (rises < n) ? exp_id[rises] : -1, rises);
        end
        rises++;
      end
      prev_req = req;
    end
    vectors++;
    if (rises != n || grants != n || busy) begin
      miscompares++;
      $display("FAIL traffic_done: got grants=%0d reqs=%0d busy=%0b want %0d/%0d/0",
               grants, rises, busy, n, n);
    end
    ack = 1'b0;
    src_valid = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ack = 1'b0;
    src_valid = '1;
    src_data = 32'hDEAD_BEEF;
    repeat (3) @(negedge tx_clk);
    #1;
    vectors++; if (req !== 1'b0) begin miscompares++; $display("FAIL reset_req: got %b want 0", req); end
    vectors++; if (tx_data_out !== 8'h00) begin miscompares++; $display("FAIL reset_data: got %h want 00", tx_data_out); end
    vectors++; if (grant_id !== 2'd0) begin miscompares++; $display("FAIL reset_grant_id: got %0d want 0", grant_id); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b want 0", err); end
    vectors++; if (src_ready !== 4'b0000) begin miscompares++; $display("FAIL reset_src_ready: got %b want 0000", src_ready); end
    @(negedge tx_clk);
    src_valid = '0;
    reset = 1'b0;
  endtask

  task automatic test_single();
    @(negedge tx_clk);
    src_data = 32'h00A5_0000;
    src_valid = 4'b0100;
    #1;
    vectors++; if (src_ready !== 4'b0100) begin miscompares++; $display("FAIL single_ready: got %b want 0100", src_ready); end
    @(negedge tx_clk);
    src_valid = '0;
    #1;
    vectors++; if (tx_data_out !== 8'hA5 || grant_id !== 2'd2) begin miscompares++; $display("FAIL single_latch: got data=%h id=%0d want A5/2", tx_data_out, grant_id); end
    vectors++; if (req !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL single_setup: got req=%b busy=%b want 0/1", req, busy); end
    vectors++; if (src_ready !== 4'b0000) begin miscompares++; $display("FAIL single_ready_off: got %b want 0000", src_ready); end
    @(negedge tx_clk);
    #1;
    vectors++; if (req !== 1'b1 || tx_data_out !== 8'hA5) begin miscompares++; $display("FAIL single_req_rise: got req=%b data=%h want 1/A5", req, tx_data_out); end
    repeat (4) @(negedge tx_clk);
    ack = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      @(negedge tx_clk);
      #1;
      vectors++;
      if (req !== (e < 3)) begin
        miscompares++;
        $display("FAIL single_ack_latency: edge %0d got req=%b want %b", e, req, (e < 3));
      end
    end
    ack = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      @(negedge tx_clk);
      #1;
      vectors++;
      if (busy !== (e < 3)) begin
        miscompares++;
        $display("FAIL single_release: edge %0d got busy=%b want %b", e, busy, (e < 3));
      end
    end
  endtask

  task automatic test_stale_ack();
    bit got;
    reset = 1'b1;
    ack = 1'b1;
    src_valid = '0;
    repeat (2) @(negedge tx_clk);
    reset = 1'b0;
    repeat (3) @(negedge tx_clk);
    src_data = 32'h1122_333C;
    src_valid = 4'b0001;
    for (int c = 0; c < 6; c++) begin
      @(negedge tx_clk);
      #1;
      vectors++;
      if (src_ready !== 4'b0000 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL stale_blocked: cycle %0d got ready=%b busy=%b want 0000/0", c, src_ready, busy);
      end
    end
    ack = 1'b0;
    got = 0;
    for (int c = 0; c < 3 && !got; c++) begin
      @(negedge tx_clk);
      #1;
      if (src_ready === 4'b0001) got = 1;
    end
    vectors++; if (!got) begin miscompares++; $display("FAIL stale_grant: got no src_ready within 3 cycles want 0001"); end
    @(negedge tx_clk);
    src_valid = '0;
    got = 0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge tx_clk);
      #1;
      if (req) got = 1;
    end
    vectors++; if (!got || tx_data_out !== 8'h3C) begin miscompares++; $display("FAIL stale_xfer: got req_seen=%0d data=%h want 1/3C", got, tx_data_out); end
    ack = 1'b1;
    got = 0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge tx_clk);
      #1;
      if (!req) got = 1;
    end
    ack = 1'b0;
    for (int c = 0; c < 10 && got; c++) begin
      @(negedge tx_clk);
      #1;
      if (!busy) got = 0;
    end
    vectors++; if (got || req !== 1'b0) begin miscompares++; $display("FAIL stale_finish: got busy=%b req=%b want 0/0", busy, req); end
  endtask

  task automatic test_reset_mid();
    bit got;
    @(negedge tx_clk);
    src_data = 32'h0000_5A00;
    src_valid = 4'b0010;
    got = 0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge tx_clk);
      src_valid = 4'b1111;
      #1;
      if (req) got = 1;
    end
    vectors++; if (!got || grant_id !== 2'd1) begin miscompares++; $display("FAIL midrst_start: got req_seen=%0d id=%0d want 1/1", got, grant_id); end
    #2;
    reset = 1'b1;
    #1;
    vectors++;
    if (req !== 1'b0 || busy !== 1'b0 || tx_data_out !== 8'h00 || grant_id !== 2'd0) begin
      miscompares++;
      $display("FAIL midrst_async: got req=%b busy=%b data=%h id=%0d want 0/0/00/0", req, busy, tx_data_out, grant_id);
    end
    @(negedge tx_clk);
    reset = 1'b0;
    ack = 1'b0;
    #1;
    vectors++; if (src_ready !== 4'b0001) begin miscompares++; $display("FAIL midrst_ptr: got %b want 0001", src_ready); end
    src_valid = '0;
    @(negedge tx_clk);
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < NS; i++) begin
      src_q[i].delete();
      src_q[i].push_back(8'(8'h10 * i + 8'h01));
      src_q[i].push_back(8'(8'h10 * i + 8'h02));
    end
    exp_id   = '{0, 1, 2, 3, 0, 1, 2, 3};
    exp_byte = '{8'h01, 8'h11, 8'h21, 8'h31, 8'h02, 8'h12, 8'h22, 8'h32};
    run_traffic(4, 600);
  endtask

  task automatic test_random();
    do_reset();
    mdl_ptr = 0;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < NS; i++) begin
        int len;
        src_q[i].delete();
        len = $urandom_range(0, 3);
        for (int j = 0; j < len; j++) src_q[i].push_back(8'($urandom));
      end
      build_expected();
      run_traffic($urandom_range(1, 5), 1500);
    end
  endtask

  task automatic test_timeout();
    bit got;
    int first_err, err_cycles, bad;
    logic req_at_err, busy_after;
    do_reset();
    @(negedge tx_clk);
    src_data = 32'h0000_0077;
    src_valid = 4'b0001;
    @(negedge tx_clk);
    src_valid = '0;
    got = 0;
    for (int c = 0; c < 5 && !got; c++) begin
      @(negedge tx_clk);
      #1;
      if (req) got = 1;
    end
    vectors++; if (!got) begin miscompares++; $display("FAIL timeout_req_rise: got req=%b want 1", req); end
`ifdef HAND_ARB_TIMEOUT_EN
    first_err = -1;
    err_cycles = 0;
    req_at_err = 1'b1;
    busy_after = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge tx_clk);
      #1;
      if (err) begin
        err_cycles++;
        if (first_err < 0) begin
          first_err = n;
          req_at_err = req;
        end
      end
      if (n == TO + 1) busy_after = busy;
    end
    vectors++; if (first_err != TO) begin miscompares++; $display("FAIL timeout_err_time: got %0d want %0d", first_err, TO); end
    vectors++; if (err_cycles != 1) begin miscompares++; $display("FAIL timeout_err_width: got %0d want 1", err_cycles); end
    vectors++; if (req_at_err !== 1'b0 || busy_after !== 1'b0) begin miscompares++; $display("FAIL timeout_recover: got req=%b busy=%b want 0/0", req_at_err, busy_after); end
`else
    bad = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge tx_clk);
      #1;
      if (req !== 1'b1 || err !== 1'b0 || busy !== 1'b1) bad++;
    end
    vectors++; if (bad != 0) begin miscompares++; $display("FAIL timeout_absent_hold: got %0d bad cycles want 0", bad); end
`endif
    do_reset();
  endtask

  initial begin
    reset = 1'b1;
    ack = 1'b0;
    src_valid = '0;
    src_data = '0;
    test_reset();
    test_single();
    test_stale_ack();
    test_reset_mid();
    test_round_robin();
    test_random();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
